ccd_pixel_capture: RTL and testbench

CCD_PIXEL_CAPTURE -- requirements
Module: ccd_pixel_capture

---
 rtl/ccd_pixel_capture.sv | 168 ++++++++++++++++
 tb/tb_ccd_pixel_capture.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ccd_pixel_capture.sv
// ccd_pixel_capture: aligns CCD timing to the ADC pipeline, clamps optical black,
// frames active pixels into lines/frames and buffers them in a small FIFO.
module ccd_pixel_capture #(
    parameter int DATA_W      = 12,
    parameter int ADC_LAT     = 3,
    parameter int LINE_PIXELS = 776,
    parameter int FRAME_LINES = 1040,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              hblank,
    input  logic              cob,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              pix_ready,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_sol,
    output logic              pix_sof,
    output logic [DATA_W-1:0] black_level,
    output logic              overflow
);
    localparam int XW = $clog2(LINE_PIXELS + 1);
    localparam int LW = $clog2(FRAME_LINES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_LINE, ACTIVE, LINE_DONE} state_t;

    logic [ADC_LAT-1:0] hb_sr, cob_sr;
    logic               hb_d, cob_d, cob_q, cob_fall;
    logic [DATA_W+3:0]  acc;
    logic [4:0]         bcnt;
    state_t             state, nxt;
    logic [XW-1:0]      x_cnt, x_nxt;
    logic [LW-1:0]      line_cnt, line_nxt;
    logic               sof_pending, sofp_nxt, cap;
    logic               cap_v, cap_sol, cap_sof;
    logic [DATA_W-1:0]  cap_data;
    logic [DATA_W+1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        cnt;
    logic               full, wr, rd;

    assign hb_d     = hb_sr[ADC_LAT-1];
    assign cob_d    = cob_sr[ADC_LAT-1];
    assign cob_fall = cob_q & ~cob_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hb_sr  <= '0;
            cob_sr <= '0;
        end else begin
            hb_sr  <= ADC_LAT'({hb_sr, hblank});
            cob_sr <= ADC_LAT'({cob_sr, cob});
        end
    end

    // Clamp: average of the first 16 black samples, committed only if 16 were seen
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc         <= '0;
            bcnt        <= '0;
            cob_q       <= 1'b0;
            black_level <= '0;
        end else begin
            cob_q <= cob_d;
            if (cob_fall) begin
                acc  <= '0;
                bcnt <= '0;
                if (bcnt == 5'd16) black_level <= acc[DATA_W+3:4];
            end else if (cob_d && bcnt != 5'd16) begin
                acc  <= acc + (DATA_W+4)'(adc_data);
                bcnt <= bcnt + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            x_cnt       <= '0;
            line_cnt    <= '0;
            sof_pending <= 1'b0;
        end else begin
            state       <= nxt;
            x_cnt       <= x_nxt;
            line_cnt    <= line_nxt;
            sof_pending <= sofp_nxt;
        end
    end

    always_comb begin
        nxt      = state;
        x_nxt    = x_cnt;
        line_nxt = line_cnt;
        sofp_nxt = sof_pending;
        cap      = 1'b0;
        if (frame_start) begin
            nxt      = WAIT_LINE;
            x_nxt    = '0;
            line_nxt = '0;
            sofp_nxt = 1'b1;
        end else begin
            case (state)
                WAIT_LINE: if (!hb_d) begin
                    cap   = 1'b1;
                    x_nxt = XW'(1);
                    nxt   = (LINE_PIXELS == 1) ? LINE_DONE : ACTIVE;
                end
                ACTIVE: if (!hb_d) begin
                    cap   = 1'b1;
                    x_nxt = x_cnt + 1'b1;
                    if (x_cnt == XW'(LINE_PIXELS - 1)) nxt = LINE_DONE;
                end
                default: ;
            endcase
            // Line end: either the full count was reached or blanking cut it short
            if ((state == ACTIVE || state == LINE_DONE) && hb_d) begin
                x_nxt    = '0;
                line_nxt = line_cnt + 1'b1;
                nxt      = (line_cnt + 1'b1 == LW'(FRAME_LINES)) ? IDLE : WAIT_LINE;
            end
            if (cap) sofp_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cap_v    <= 1'b0;
            cap_data <= '0;
            cap_sol  <= 1'b0;
            cap_sof  <= 1'b0;
        end else begin
            cap_v <= cap;
            if (cap) begin
                cap_data <= (adc_data > black_level) ? adc_data - black_level : '0;
                cap_sol  <= (x_cnt == '0);
                cap_sof  <= sof_pending;
            end
        end
    end

    assign full = (cnt == (AW+1)'(FIFO_DEPTH));
    assign rd   = pix_valid & pix_ready;
    assign wr   = cap_v & (~full | rd);

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= {cap_data, cap_sol, cap_sof};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
            if (cap_v && !wr) overflow <= 1'b1;
        end
    end

    assign pix_valid = (cnt != '0);
    assign {pix_data, pix_sol, pix_sof} = pix_valid ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_ccd_pixel_capture.sv
// tb_ccd_pixel_capture: directed bench with a saturation vector table and
// hand-written line/frame/clamp/backpressure/reset sequences.
module tb_ccd_pixel_capture;
    localparam int DW  = 12;
    localparam int LAT = 3;
    localparam int LP  = 776;
    localparam int FL  = 4;
    localparam int FD  = 16;

    logic          clk = 1'b0;
    logic          reset, frame_start, hblank, cob, pix_ready;
    logic [DW-1:0] adc_data;
    logic          pix_valid, pix_sol, pix_sof, overflow;
    logic [DW-1:0] pix_data, black_level;

    typedef struct {int d; bit sol; bit sof;} word_t;
    typedef struct {int adc; int exp;} vec_t;

    word_t got[$];
    int    px[$];
    vec_t  tbl[8];
    int    nchk = 0, nerr = 0, cyc = 0, t_fall = 0, t_valid = -1;
    bit    arm = 0;

    ccd_pixel_capture #(.DATA_W(DW), .ADC_LAT(LAT), .LINE_PIXELS(LP),
                        .FRAME_LINES(FL), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .hblank(hblank),
        .cob(cob), .adc_data(adc_data), .pix_ready(pix_ready),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_sol(pix_sol),
        .pix_sof(pix_sof), .black_level(black_level), .overflow(overflow));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pix_valid && pix_ready) got.push_back('{int'(pix_data), pix_sol, pix_sof});
        if (arm && pix_valid) begin
            t_valid = cyc;
            arm = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int gd(int k);
        return (k < got.size()) ? got[k].d : -1;
    endfunction
    function automatic int gsol(int k);
        return (k < got.size()) ? int'(got[k].sol) : -1;
    endfunction
    function automatic int gsof(int k);
        return (k < got.size()) ? int'(got[k].sof) : -1;
    endfunction

    task automatic pulse_fs();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    // hblank low for n cycles; px[] appears at adc_data LAT cycles later, as the AFE would
    task automatic run_line(input int n, input int tail);
        for (int i = 0; i < n + tail; i++) begin
            hblank   = (i < n) ? 1'b0 : 1'b1;
            adc_data = (i >= LAT && i - LAT < px.size()) ? DW'(px[i-LAT]) : '0;
            if (i == 0) t_fall = cyc;
            step();
        end
    endtask

    task automatic run_cob(input int n, input int val);
        for (int i = 0; i < n + LAT + 3; i++) begin
            cob      = (i < n);
            adc_data = DW'(val);
            step();
        end
        cob = 1'b0;
    endtask

    initial begin
        tbl[0] = '{50, 0};     tbl[1] = '{300, 236};  tbl[2] = '{64, 0};    tbl[3] = '{65, 1};
        tbl[4] = '{4095, 4031}; tbl[5] = '{0, 0};     tbl[6] = '{1000, 936}; tbl[7] = '{63, 0};

        reset = 1'b0; frame_start = 1'b0; hblank = 1'b1; cob = 1'b0;
        pix_ready = 1'b1; adc_data = '0;
        repeat (4) step();
        chk("rst_valid", pix_valid, 0);
        chk("rst_data", pix_data, 0);
        chk("rst_sol", pix_sol, 0);
        chk("rst_sof", pix_sof, 0);
        chk("rst_black", black_level, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b1;
        repeat (5) step();

        // Full line, no clamp
        px.delete();
        for (int i = 0; i < LP; i++) px.push_back(100 + i);
        got.delete();
        pulse_fs();
        arm = 1;
        run_line(LP, 10);
        begin
            int bad = 0;
            for (int i = 0; i < LP; i++) if (gd(i) != 100 + i) bad++;
            chk("line_count", got.size(), LP);
            chk("line_bad_words", bad, 0);
            chk("line_first", gd(0), 100);
            chk("line_last", gd(LP - 1), 875);
            chk("line_sol0", gsol(0), 1);
            chk("line_sof0", gsof(0), 1);
            chk("line_sol1", gsol(1), 0);
            chk("line_sof1", gsof(1), 0);
            chk("latency", t_valid - t_fall, LAT + 2);
        end

        // Clamp of 27 cycles at 64, then saturation table on a short line
        run_cob(27, 64);
        chk("black_64", black_level, 64);
        px.delete();
        foreach (tbl[i]) px.push_back(tbl[i].adc);
        got.delete();
        run_line(8, 10);
        chk("tbl_count", got.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("tbl_%0d", i), gd(i), tbl[i].exp);
        chk("tbl_sol", gsol(0), 1);
        chk("tbl_sof", gsof(0), 0);

        // Short clamp window leaves the estimate alone
        run_cob(10, 200);
        chk("black_short", black_level, 64);

        // Backpressure for a whole line
        px.delete();
        for (int i = 0; i < 1000; i++) px.push_back(500 + i);
        got.delete();
        pix_ready = 1'b0;
        run_line(LP, 10);
        chk("bp_ovf", overflow, 1);
        chk("bp_valid", pix_valid, 1);
        chk("bp_sol", pix_sol, 1);
        chk("bp_sof", pix_sof, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", pix_data, 436);
            step();
        end
        pix_ready = 1'b1;
        repeat (20) step();
        chk("bp_drain", got.size(), FD);
        chk("bp_last", gd(FD - 1), 451);

        // Early line end and full frame of FL lines
        px.delete();
        for (int i = 0; i < 1000; i++) px.push_back(100 + i);
        got.delete();
        pulse_fs();
        run_line(500, 10);
        for (int l = 0; l < FL - 1; l++) run_line(5, 10);
        run_line(5, 10);
        chk("frm_count", got.size(), 500 + 5 * (FL - 1));
        chk("frm_499", gd(499), 535);
        chk("frm_500", gd(500), 36);
        chk("frm_sol499", gsol(499), 0);
        chk("frm_sol500", gsol(500), 1);
        chk("frm_sof0", gsof(0), 1);
        chk("frm_sof500", gsof(500), 0);
        chk("frm_ovf_sticky", overflow, 1);

        // frame_start in the middle of a line
        got.delete();
        pulse_fs();
        for (int i = 0; i < 60; i++) begin
            hblank = (i < 50) ? 1'b0 : 1'b1;
            adc_data = DW'(1000 + i);
            frame_start = (i == 30);
            step();
        end
        frame_start = 1'b0;
        chk("fs_count", got.size(), 49);
        chk("fs_26", gd(26), 965);
        chk("fs_27", gd(27), 967);
        chk("fs_sol27", gsol(27), 1);
        chk("fs_sof27", gsof(27), 1);
        chk("fs_sof26", gsof(26), 0);
        chk("fs_sol28", gsol(28), 0);

        // Reset in the middle of a line
        pulse_fs();
        hblank = 1'b0;
        adc_data = DW'(500);
        repeat (20) step();
        reset = 1'b0;
        step();
        chk("rr_valid", pix_valid, 0);
        chk("rr_data", pix_data, 0);
        chk("rr_black", black_level, 0);
        chk("rr_ovf", overflow, 0);
        reset = 1'b1;
        got.delete();
        repeat (20) step();
        chk("rr_idle", got.size(), 0);
        px.delete();
        for (int i = 0; i < 10; i++) px.push_back(100 + i);
        pulse_fs();
        run_line(10, 10);
        chk("rr_resume_count", got.size(), 13);
        chk("rr_resume_3", gd(3), 100);
        chk("rr_resume_12", gd(12), 109);
        chk("rr_resume_sof", gsof(0), 1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
